mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 32, datapath width; only 32 supported.
REQ-002 Parameter: TIMEOUT_CYCLES, 255, max WAIT cycles before a load is aborted.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 MemReadM / MemWriteM  in  1 each  M-stage load / store request.
REQ-006 ALUResultM  in  32  byte address.
REQ-007 WriteDataM  in  32  store data, unaligned in bits [7:0]/[15:0]/[31:0].
REQ-008 LS_modeM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 mem_req_valid  out  1 / mem_req_ready  in  1  request handshake.
REQ-010 mem_we  out  1; mem_addr  out  32 (bits[1:0]=0); mem_wdata  out  32; mem_be  out  4.
REQ-011 mem_rsp_valid  in  1; mem_rdata  in  32  load response word.
REQ-012 ReadDataM  out  32  formatted load result.
REQ-013 StallM  out  1  freezes PC, F/D, D/E, E/M registers while high.
REQ-014 MisalignM / TimeoutM  out  1 each  single-cycle error pulses.
REQ-015 stall_count  out  32  saturating count of StallM-high cycles.

Function
REQ-016 FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-017 IDLE: access = MemReadM|MemWriteM; MemWriteM has priority if both high.
REQ-018 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0 -> MisalignM=1 same cycle (combinational), no request, no stall, stay IDLE.
REQ-019 Aligned access in IDLE -> StallM=1 same cycle; latch addr, data, mode, we; next state REQ.
REQ-020 LS_mode 011/110/111 treated as W.
REQ-021 REQ: mem_req_valid=1; mem_addr, mem_we, mem_wdata, mem_be held stable until mem_req_ready=1.
REQ-022 REQ handshake: store -> DONE; load -> WAIT with timeout counter cleared.
REQ-023 Store format: B -> wdata={4{byte}}, be=0001<<addr[1:0]; H -> {2{half}}, be=0011<<addr[1:0]; W -> be=1111. Loads: be=1111, we=0.
REQ-024 WAIT: mem_rsp_valid=1 -> ReadDataM <= formatted data, go DONE.
REQ-025 Load format: lane = mem_rdata >> (8*addr[1:0]); B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-026 WAIT: counter reaches TIMEOUT_CYCLES without response -> ReadDataM <= 0, TimeoutM pulses 1 cycle, go DONE.
REQ-027 StallM = (IDLE & aligned access) | REQ | WAIT; StallM=0 in DONE.
REQ-028 DONE: lasts exactly 1 cycle, ignores M-stage inputs (stale instruction), returns to IDLE.
REQ-029 Minimum latency: store 2 stall cycles (IDLE, REQ with ready=1); load 3 (IDLE, REQ, WAIT with rsp in first WAIT cycle).
REQ-030 mem_rsp_valid outside WAIT ignored; mem_req_valid=0 outside REQ.
REQ-031 ReadDataM holds last load result until next load completes.
REQ-032 stall_count +1 per StallM-high cycle, saturates at 0xFFFFFFFF.

Reset
REQ-033 rst=1 at any edge, including mid-REQ/WAIT -> state IDLE; mem_req_valid, StallM, MisalignM, TimeoutM = 0 after edge; ReadDataM=0, stall_count=0, latched registers 0.
REQ-034 In-flight response arriving after reset is ignored; no re-issue of aborted access.

Verification
REQ-035 SB addr 0x1003, WriteDataM 0x000000AB, ready=1 immediately -> mem_addr 0x1000, mem_be 1000, mem_wdata 0xABABABAB, StallM high 2 cycles.
REQ-036 LH addr 0x2002, rsp 2 cycles after accept, mem_rdata 0x8001_1234 -> ReadDataM 0xFFFF8001, StallM high 4 cycles; LHU same -> 0x00008001.
REQ-037 LW addr 0x3001 -> MisalignM=1 one cycle, mem_req_valid never asserts, StallM=0.
REQ-038 LW with ready delayed 3 cycles -> mem_req_valid and address stable all 3 cycles; no response for 255 WAIT cycles -> TimeoutM pulse, ReadDataM=0.
REQ-039 rst asserted during WAIT, then rsp_valid -> IDLE, StallM=0, ReadDataM=0, stall_count=0; late rsp ignored.
REQ-040 Back-to-back LW then SW -> each issued exactly once; stall_count equals total StallM-high cycles.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Memory-side request/response bundle between the M-stage controller and data memory.
// Master issues requests and consumes load responses; slave is the memory.
interface mem_stage_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// M-stage load/store controller: stalls the pipeline across a valid/ready memory request and response.
// Store stalls >= 2 cycles, load >= 3; request held stable until ready; loads abort after TIMEOUT_CYCLES.
module mem_stage_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [2:0]            LS_modeM,
  mem_stage_ctrl_if.master      mem,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  TimeoutM,
  output logic [31:0]           stall_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d;
  logic [2:0]            mode_q, mode_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  timeout_q, timeout_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;

  logic                  access;
  logic                  size_byte;
  logic                  size_half;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic                  stall;
  logic                  misalign;
  logic                  req_valid;

  // Modes 011/110/111 share the low-bit pattern of a word access.
  assign size_byte = (LS_modeM[1:0] == 2'b00);
  assign size_half = (LS_modeM[1:0] == 2'b01);
  assign access    = (MemReadM | MemWriteM) & ~rst;

  always_comb begin
    misaligned = 1'b0;
    if (size_half) begin
      misaligned = ALUResultM[0];
    end else if (!size_byte) begin
      misaligned = |ALUResultM[1:0];
    end
  end

  always_comb begin
    st_wdata = WriteDataM;
    st_be    = 4'b1111;
    if (size_byte) begin
      st_wdata = {4{WriteDataM[7:0]}};
      st_be    = 4'b0001 << ALUResultM[1:0];
    end else if (size_half) begin
      st_wdata = {2{WriteDataM[15:0]}};
      st_be    = 4'b0011 << ALUResultM[1:0];
    end
  end

  assign lane = mem.mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (mode_q)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_fmt = {24'd0, lane[7:0]};
      3'b101:  load_fmt = {16'd0, lane[15:0]};
      default: load_fmt = lane;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    we_d      = we_q;
    mode_d    = mode_q;
    timer_d   = timer_q;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    stall     = 1'b0;
    misalign  = 1'b0;
    req_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            misalign = 1'b1;
          end else begin
            stall   = 1'b1;
            addr_d  = ALUResultM;
            mode_d  = LS_modeM;
            we_d    = MemWriteM;
            wdata_d = MemWriteM ? st_wdata : '0;
            be_d    = MemWriteM ? st_be : 4'b1111;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall     = 1'b1;
        req_valid = 1'b1;
        if (mem.mem_req_ready) begin
          timer_d = '0;
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem.mem_rsp_valid) begin
          rdata_d = load_fmt;
          state_d = DONE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      we_q        <= 1'b0;
      mode_q      <= '0;
      timer_q     <= '0;
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      we_q        <= we_d;
      mode_q      <= mode_d;
      timer_q     <= timer_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_we        = we_q;
  assign mem.mem_addr      = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem.mem_wdata     = wdata_q;
  assign mem.mem_be        = be_q;

  assign ReadDataM   = rdata_q;
  assign StallM      = stall;
  assign MisalignM   = misalign;
  assign TimeoutM    = timeout_q;
  assign stall_count = stall_cnt_q;

  a_req_stable : assert property (@(posedge clk) disable iff (rst)
    (mem.mem_req_valid && !mem.mem_req_ready) |=>
      (mem.mem_req_valid && $stable(mem.mem_addr) && $stable(mem.mem_be) &&
       $stable(mem.mem_wdata) && $stable(mem.mem_we)));

  a_no_stall_on_misalign : assert property (@(posedge clk) !(MisalignM && StallM));

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: request expectations and load results queued at drive time.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  LS_modeM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, TimeoutM;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  mem_stage_ctrl_if mif ();

  mem_stage_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .LS_modeM(LS_modeM),
    .mem(mif),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
    .TimeoutM(TimeoutM), .stall_count(stall_count)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] res_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          rdy_dly = 0;
  int          rsp_dly = 0;
  logic [31:0] rsp_word = '0;
  int          issued = 0;
  int          total_stalls = 0;
  int          vcyc = 0;
  int          wcnt = 0;
  bit          pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic req_t model_req(input logic st, input logic [2:0] m,
                                     input logic [31:0] a, input logic [31:0] w);
    req_t r;
    logic [3:0] one_b;
    logic [3:0] two_b;
    one_b   = 4'b0001;
    two_b   = 4'b0011;
    r.we    = st;
    r.addr  = {a[31:2], 2'b00};
    r.be    = 4'b1111;
    r.wdata = w;
    if (st) begin
      if (m[1:0] == 2'b00) begin
        r.wdata = {4{w[7:0]}};
        r.be    = one_b << a[1:0];
      end else if (m[1:0] == 2'b01) begin
        r.wdata = {2{w[15:0]}};
        r.be    = two_b << a[1:0];
      end
    end
    return r;
  endfunction

  // Memory model: accepts after rdy_dly valid cycles, answers loads rsp_dly cycles after accept.
  initial begin
    mif.mem_req_ready = 1'b0;
    mif.mem_rsp_valid = 1'b0;
    mif.mem_rdata     = '0;
    forever begin
      @(negedge clk);
      mif.mem_req_ready = 1'b0;
      mif.mem_rsp_valid = 1'b0;
      if (pend) begin
        wcnt--;
        if (wcnt == 0) begin
          mif.mem_rsp_valid = 1'b1;
          mif.mem_rdata     = rsp_word;
          pend              = 1'b0;
        end
      end
      if (mif.mem_req_valid) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("req_addr", mif.mem_addr, req_q[0].addr);
          if (vcyc == rdy_dly) begin
            mif.mem_req_ready = 1'b1;
            chk("req_we", {31'd0, mif.mem_we}, {31'd0, req_q[0].we});
            chk("req_be", {28'd0, mif.mem_be}, {28'd0, req_q[0].be});
            if (req_q[0].we) chk("req_wdata", mif.mem_wdata, req_q[0].wdata);
            if (!req_q[0].we && rsp_dly > 0) begin
              pend = 1'b1;
              wcnt = rsp_dly;
            end
            issued++;
            void'(req_q.pop_front());
            vcyc = 0;
          end else begin
            vcyc++;
          end
        end
      end else begin
        vcyc = 0;
      end
    end
  end

  task automatic run_op(input string tag, input logic st, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int rdy, input int rsp, input logic [31:0] rword,
                        input logic [31:0] exp_rd, input int exp_stalls, input int exp_to);
    int stalls = 0;
    int tos    = 0;
    int iss0;
    bit done   = 1'b0;
    req_q.push_back(model_req(st, mode, addr, wd));
    if (!st) res_q.push_back(exp_rd);
    rdy_dly  = rdy;
    rsp_dly  = rsp;
    rsp_word = rword;
    iss0     = issued;
    @(negedge clk);
    MemWriteM  = st;
    MemReadM   = !st;
    ALUResultM = addr;
    WriteDataM = wd;
    LS_modeM   = mode;
    for (int c = 0; c < 600 && !done; c++) begin
      #1;
      if (TimeoutM) tos++;
      if (StallM) begin
        stalls++;
        @(negedge clk);
      end else begin
        done      = 1'b1;
        MemWriteM = 1'b0;
        MemReadM  = 1'b0;
        if (!st && res_q.size() > 0) chk({tag, "_rdata"}, ReadDataM, res_q.pop_front());
      end
    end
    if (!done) chk({tag, "_done_bound"}, 32'd0, 32'd1);
    chk({tag, "_stalls"}, stalls, exp_stalls);
    chk({tag, "_timeout"}, tos, exp_to);
    chk({tag, "_issued"}, issued - iss0, 32'd1);
    total_stalls += stalls;
  endtask

  task automatic run_mis(input string tag, input logic st, input logic [2:0] mode,
                         input logic [31:0] addr);
    int iss0;
    iss0 = issued;
    @(negedge clk);
    MemWriteM  = st;
    MemReadM   = !st;
    ALUResultM = addr;
    LS_modeM   = mode;
    #1;
    chk({tag, "_misalign"}, {31'd0, MisalignM}, 32'd1);
    chk({tag, "_stall"}, {31'd0, StallM}, 32'd0);
    chk({tag, "_valid"}, {31'd0, mif.mem_req_valid}, 32'd0);
    @(negedge clk);
    MemWriteM = 1'b0;
    MemReadM  = 1'b0;
    #1;
    chk({tag, "_pulse_end"}, {31'd0, MisalignM}, 32'd0);
    chk({tag, "_no_req"}, {31'd0, mif.mem_req_valid}, 32'd0);
    chk({tag, "_no_issue"}, issued - iss0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ALUResultM = '0;
    WriteDataM = '0;
    LS_modeM   = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_valid", {31'd0, mif.mem_req_valid}, 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_count", stall_count, 32'd0);
    chk("rst_timeout", {31'd0, TimeoutM}, 32'd0);
    chk("rst_misalign", {31'd0, MisalignM}, 32'd0);
    rst = 1'b0;

    run_op("sb", 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'd0, 32'd0, 2, 0);
    run_op("lh", 1'b0, 3'b001, 32'h0000_2002, 32'd0, 0, 2, 32'h8001_1234, 32'hFFFF_8001, 4, 0);
    run_op("lhu", 1'b0, 3'b101, 32'h0000_2002, 32'd0, 0, 2, 32'h8001_1234, 32'h0000_8001, 4, 0);
    run_mis("lw_mis", 1'b0, 3'b010, 32'h0000_3001);
    run_mis("sh_mis", 1'b1, 3'b001, 32'h0000_7001);
    run_mis("lhu_mis", 1'b0, 3'b101, 32'h0000_3003);
    run_op("lb", 1'b0, 3'b000, 32'h0000_6003, 32'd0, 1, 1, 32'h8000_0000, 32'hFFFF_FF80, 4, 0);
    run_op("lbu", 1'b0, 3'b100, 32'h0000_6001, 32'd0, 0, 3, 32'h0000_F100, 32'h0000_00F1, 5, 0);
    run_op("sh", 1'b1, 3'b001, 32'h0000_7002, 32'hFFFF_BEEF, 1, 0, 32'd0, 32'd0, 3, 0);
    run_op("lw011", 1'b0, 3'b011, 32'h0000_8000, 32'd0, 0, 1, 32'h1122_3344, 32'h1122_3344, 3, 0);
    run_op("lw_to", 1'b0, 3'b010, 32'h0000_3000, 32'd0, 3, 0, 32'd0, 32'd0, 260, 1);
    @(negedge clk);
    #1;
    chk("lw_to_pulse_end", {31'd0, TimeoutM}, 32'd0);
    chk("pre_rst_count", stall_count, total_stalls);
    run_op("lw", 1'b0, 3'b010, 32'h0000_9000, 32'd0, 0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 3, 0);

    // Reset while the load sits in WAIT; the late response must be ignored.
    req_q.push_back(model_req(1'b0, 3'b010, 32'h0000_4000, 32'd0));
    rdy_dly  = 0;
    rsp_dly  = 4;
    rsp_word = 32'h0000_0055;
    @(negedge clk);
    MemReadM   = 1'b1;
    ALUResultM = 32'h0000_4000;
    LS_modeM   = 3'b010;
    @(negedge clk);
    @(negedge clk);
    MemReadM = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wrst_stall", {31'd0, StallM}, 32'd0);
    chk("wrst_valid", {31'd0, mif.mem_req_valid}, 32'd0);
    chk("wrst_rdata", ReadDataM, 32'd0);
    chk("wrst_count", stall_count, 32'd0);
    total_stalls = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("late_rsp_rdata", ReadDataM, 32'd0);
    chk("late_rsp_stall", {31'd0, StallM}, 32'd0);
    chk("late_rsp_count", stall_count, 32'd0);

    run_op("b2b_lw", 1'b0, 3'b010, 32'h0000_5000, 32'd0, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 0);
    run_op("b2b_sw", 1'b1, 3'b010, 32'h0000_5004, 32'h1234_5678, 0, 0, 32'd0, 32'd0, 2, 0);
    chk("b2b_count", stall_count, total_stalls);
    chk("sb_empty", req_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
